// File: rtl/scale_mux_pkg.sv
// Shared types, constants and helpers for the scale_mux family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: smux_mode_e selection mode, ERR_CNT_W illegal-select counter
// width, sel_legal() select legality check.
package scale_mux_pkg;

  typedef enum logic [0:0] {
    SMUX_FIXED = 1'b0,
    SMUX_RR    = 1'b1
  } smux_mode_e;

  localparam int ERR_CNT_W = 16;

  // A select is legal when it is fully known and addresses an existing
  // channel. Synthesis sees only the range check; X/Z cannot exist there.
  function automatic logic sel_legal(input logic [31:0] sel, input int unsigned nch);
    logic ok;
    ok = (sel < nch);
`ifndef SYNTHESIS
    if ($isunknown(sel)) ok = 1'b0;
`endif
    return ok;
  endfunction

endpackage

// File: rtl/scale_mux_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last winner.
// Latency: grant is combinational from req/ptr; ptr updates on the edge after advance.
// Backpressure: ptr only moves on advance, so an unaccepted grant is held.
// Ports: clk, rst_n (async, active-low), req[NCH], advance (transfer taken)
//        -> grant[NCH] one-hot or zero, grant_idx, ptr (last winner).
module scale_mux_rr_arb
  import scale_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx,
  output logic [SELW-1:0] ptr
);

  logic            found;
  logic [SELW-1:0] cand;

  // Search ptr+1, ptr+2, ... wrapping modulo NCH; ptr itself is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = SELW'((int'(ptr) + i) % NCH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset to NCH-1 so the first search after reset starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SELW'(NCH - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/scale_mux_pipe.sv
// N-channel valid/ready mux (fixed sel or round-robin) into a one-deep output register.
// Latency: 1 cycle from input handshake to out_valid; full throughput, no bubble on drain+load.
// Backpressure: in_ready only when the output register is empty or draining; one-hot or zero.
// Ports: clk, rst_n (async, active-low); in_valid[NCH], in_data[NCH*WIDTH] (ch c at
//        [c*WIDTH +: WIDTH]), in_ready[NCH]; sel (MODE 0); out_valid, out_data, out_ch, out_ready.
// Optional (macro SCALE_MUX_SELCHK_EN): sel_err illegal-select pulse, err_cnt saturating count.
module scale_mux_pipe
  import scale_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
`ifdef SCALE_MUX_SELCHK_EN
  ,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam smux_mode_e MODE_E = (MODE == 1) ? SMUX_RR : SMUX_FIXED;

  logic            accept;
  logic            sel_ok;
  logic            xfer;
  logic [NCH-1:0]  fix_rdy;
  logic [NCH-1:0]  rr_grant;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] xfer_idx;
  logic [NCH-1:0]  rdy_sel;

  // Register can take a word if empty or if its current word leaves this cycle.
  assign accept = !out_valid || out_ready;
  assign sel_ok = sel_legal(32'(sel), NCH);

  always_comb begin
    fix_rdy = '0;
    if (accept && sel_ok) fix_rdy[sel] = 1'b1;
  end

  generate
    if (MODE_E == SMUX_RR) begin : g_rr
      logic [SELW-1:0] rr_ptr;
      scale_mux_rr_arb #(
        .NCH  (NCH),
        .SELW (SELW)
      ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .ptr       (rr_ptr)
      );
    end else begin : g_fixed
      assign rr_grant = '0;
      assign rr_idx   = '0;
    end
  endgenerate

  assign rdy_sel  = (MODE_E == SMUX_RR) ? (accept ? rr_grant : '0) : fix_rdy;
  // Reset holds out_valid low, which would otherwise make accept true.
  assign in_ready = rst_n ? rdy_sel : '0;
  assign xfer     = |(in_ready & in_valid);
  assign xfer_idx = (MODE_E == SMUX_RR) ? rr_idx : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(xfer_idx)*WIDTH +: WIDTH];
      out_ch    <= xfer_idx;
    end else if (out_ready) begin
      // Drain without reload: payload holds its last value.
      out_valid <= 1'b0;
    end
  end

`ifdef SCALE_MUX_SELCHK_EN
  logic bad_sel;
  assign bad_sel = (MODE_E == SMUX_FIXED) && accept && !sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      sel_err <= bad_sel;
      if (bad_sel && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_scale_mux_pipe.sv
// Bench for scale_mux_pipe: MODE 0 (NCH 4 and 3) and MODE 1 (NCH 4) instances.
// Table vectors, hand-written corner sequences, then random traffic vs a reference model.
// Optional sel_err/err_cnt checks compile in with SCALE_MUX_SELCHK_EN.
module tb_scale_mux_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u0: MODE 0, NCH 4
  logic [3:0]  iv0, rdy0;
  logic [31:0] id0;
  logic [1:0]  sel0, och0;
  logic        ordy0, ov0;
  logic [7:0]  od0;
  // u1: MODE 1, NCH 4
  logic [3:0]  iv1, rdy1;
  logic [31:0] id1;
  logic [1:0]  sel1, och1;
  logic        ordy1, ov1;
  logic [7:0]  od1;
  // u3: MODE 0, NCH 3
  logic [2:0]  iv3, rdy3;
  logic [23:0] id3;
  logic [1:0]  sel3, och3;
  logic        ordy3, ov3;
  logic [7:0]  od3;
`ifdef SCALE_MUX_SELCHK_EN
  logic        se0, se1, se3;
  logic [15:0] ec0, ec1, ec3;
`endif

  scale_mux_pipe #(.WIDTH(8), .NCH(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_data(id0), .in_ready(rdy0), .sel(sel0),
    .out_valid(ov0), .out_data(od0), .out_ch(och0), .out_ready(ordy0)
`ifdef SCALE_MUX_SELCHK_EN
    , .sel_err(se0), .err_cnt(ec0)
`endif
  );
  scale_mux_pipe #(.WIDTH(8), .NCH(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(rdy1), .sel(sel1),
    .out_valid(ov1), .out_data(od1), .out_ch(och1), .out_ready(ordy1)
`ifdef SCALE_MUX_SELCHK_EN
    , .sel_err(se1), .err_cnt(ec1)
`endif
  );
  scale_mux_pipe #(.WIDTH(8), .NCH(3), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_data(id3), .in_ready(rdy3), .sel(sel3),
    .out_valid(ov3), .out_data(od3), .out_ch(och3), .out_ready(ordy3)
`ifdef SCALE_MUX_SELCHK_EN
    , .sel_err(se3), .err_cnt(ec3)
`endif
  );

  int n_cmp, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  och;
  } vec_t;
  vec_t tbl[11];

  // Reference model state (random phase)
  logic        m0_ov, m1_ov, m3_ov, acc, legal;
  logic [7:0]  m0_od, m1_od, m3_od;
  logic [1:0]  m0_ch, m1_ch, m3_ch;
  int          ptr, g;
  logic [3:0]  e_rdy;
  logic [2:0]  e_rdy3;
  logic [15:0] m3_cnt;
  logic        m3_err;
  int          exp_seq[6];
  int          exp_alt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, counted %0d of required 0 hangs", 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    //             sel   iv       dat           ordy  rdy      ov    od     och
    tbl[0]  = '{2'd2, 4'b0100, 32'hEE5AEEEE, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2};
    tbl[1]  = '{2'd1, 4'b0010, 32'hEEEE11EE, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[2]  = '{2'd1, 4'b0010, 32'hEEEE33EE, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{2'd1, 4'b0010, 32'hEEEE33EE, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[4]  = '{2'd1, 4'b0010, 32'hEEEE44EE, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[5]  = '{2'd1, 4'b0010, 32'hEEEE22EE, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[6]  = '{2'd3, 4'b0000, 32'hEEEEEEEE, 1'b1, 4'b1000, 1'b0, 8'h22, 2'd1};
    tbl[7]  = '{2'd0, 4'b0001, 32'hEEEEEE7E, 1'b0, 4'b0001, 1'b1, 8'h7E, 2'd0};
    tbl[8]  = '{2'd3, 4'b1111, 32'hC3EEEEEE, 1'b0, 4'b0000, 1'b1, 8'h7E, 2'd0};
    tbl[9]  = '{2'd3, 4'b1000, 32'hC3EEEEEE, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
    tbl[10] = '{2'd2, 4'b0000, 32'hEEEEEEEE, 1'b1, 4'b0100, 1'b0, 8'hC3, 2'd3};
    exp_seq = '{0, 1, 2, 3, 0, 1};
    exp_alt = '{1, 3, 1, 3};

    // Reset state, with every channel requesting
    rst_n = 1'b0;
    sel0 = 2'd0; sel1 = 2'd0; sel3 = 2'd0;
    iv0 = 4'hF; iv1 = 4'hF; iv3 = 3'h7;
    id0 = 32'h0; id1 = 32'h0; id3 = 24'h0;
    ordy0 = 1'b1; ordy1 = 1'b1; ordy3 = 1'b1;
    #3;
    chk("rst_ov0", ov0, 0);   chk("rst_od0", od0, 0);   chk("rst_och0", och0, 0);
    chk("rst_rdy0", rdy0, 0); chk("rst_ov1", ov1, 0);   chk("rst_rdy1", rdy1, 0);
    chk("rst_rdy3", rdy3, 0);
`ifdef SCALE_MUX_SELCHK_EN
    chk("rst_ec3", ec3, 0);   chk("rst_se3", se3, 0);
`endif
    cycle();
    iv0 = 4'h0; iv1 = 4'h0; iv3 = 3'h0;
    rst_n = 1'b1;

    // MODE 0 vectors: load, stall, no-bubble reload, drain
    for (int i = 0; i < 11; i++) begin
      sel0 = tbl[i].sel; iv0 = tbl[i].iv; id0 = tbl[i].dat; ordy0 = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", i), rdy0, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d_ov", i), ov0, tbl[i].ov);
      chk($sformatf("tbl%0d_od", i), od0, tbl[i].od);
      chk($sformatf("tbl%0d_och", i), och0, tbl[i].och);
    end
    iv0 = 4'h0;

    // NCH=3: out-of-range select never transfers
    sel3 = 2'd3; iv3 = 3'b111; id3 = 24'h332211; ordy3 = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk("bad_sel_rdy", rdy3, 0);
      cycle();
      chk("bad_sel_ov", ov3, 0);
`ifdef SCALE_MUX_SELCHK_EN
      chk("bad_sel_err", se3, 1);
      chk("bad_sel_cnt", ec3, k);
`endif
    end
    sel3 = 2'd2;
    #1; chk("sel2_rdy3", rdy3, 3'b100);
    cycle();
    chk("sel2_ov3", ov3, 1); chk("sel2_od3", od3, 8'h33); chk("sel2_och3", och3, 2);
`ifdef SCALE_MUX_SELCHK_EN
    chk("sel2_err", se3, 0); chk("sel2_cnt", ec3, 2);
`endif
    sel3 = 2'd3; ordy3 = 1'b0;
    #1; chk("stall_bad_rdy3", rdy3, 0);
    cycle();
    chk("stall_bad_ov3", ov3, 1); chk("stall_bad_od3", od3, 8'h33);
`ifdef SCALE_MUX_SELCHK_EN
    chk("stall_bad_err", se3, 0); chk("stall_bad_cnt", ec3, 2);
`endif
    iv3 = 3'b000; ordy3 = 1'b1; sel3 = 2'd0;

    // MODE 1: grant held through a stall, then resumes after winner
    id1 = 32'h44332211;
    iv1 = 4'b0001; ordy1 = 1'b1;
    #1; chk("rr_a_rdy", rdy1, 4'b0001);
    cycle(); chk("rr_a_och", och1, 0); chk("rr_a_od", od1, 8'h11);
    iv1 = 4'b0100; ordy1 = 1'b0;
    #1; chk("rr_b_rdy", rdy1, 0);
    cycle(); chk("rr_b_och", och1, 0);
    iv1 = 4'b0101;
    #1; chk("rr_c_rdy", rdy1, 0);
    cycle(); chk("rr_c_od", od1, 8'h11);
    ordy1 = 1'b1;
    #1; chk("rr_d_rdy", rdy1, 4'b0100);
    cycle(); chk("rr_d_och", och1, 2); chk("rr_d_od", od1, 8'h33);
    iv1 = 4'b1001;
    #1; chk("rr_e_rdy", rdy1, 4'b1000);
    cycle(); chk("rr_e_och", och1, 3);
    iv1 = 4'b0001;
    #1; chk("rr_f_rdy", rdy1, 4'b0001);
    cycle(); chk("rr_f_och", och1, 0);

    // Async reset while holding a word
    iv1 = 4'b1111; id1 = 32'hA5A5A5A5;
    cycle(); chk("pre_rst_ov", ov1, 1); chk("pre_rst_od", od1, 8'hA5);
    ordy1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", ov1, 0); chk("mid_rst_od", od1, 0); chk("mid_rst_rdy", rdy1, 0);
    #1 rst_n = 1'b1;
    ordy1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1; chk($sformatf("rr_all%0d_rdy", k), rdy1, 32'd1 << exp_seq[k]);
      cycle(); chk($sformatf("rr_all%0d_och", k), och1, exp_seq[k]);
    end
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    iv1 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle(); chk($sformatf("rr_alt%0d_och", k), och1, exp_alt[k]);
      chk($sformatf("rr_alt%0d_ov", k), ov1, 1);
    end

    // Random traffic against the reference model
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m0_ov = 0; m0_od = 0; m0_ch = 0;
    m1_ov = 0; m1_od = 0; m1_ch = 0; ptr = 3;
    m3_ov = 0; m3_od = 0; m3_ch = 0; m3_cnt = 0; m3_err = 0;
    for (int n = 0; n < 400; n++) begin
      sel0 = 2'($urandom_range(0, 3)); iv0 = 4'($urandom); id0 = $urandom;
      ordy0 = ($urandom_range(0, 3) != 0);
      sel1 = 2'($urandom_range(0, 3)); iv1 = 4'($urandom); id1 = $urandom;
      ordy1 = ($urandom_range(0, 3) != 0);
      sel3 = 2'($urandom_range(0, 3)); iv3 = 3'($urandom); id3 = 24'($urandom);
      ordy3 = ($urandom_range(0, 3) != 0);
      #1;
      // fixed select, 4 channels
      acc = !m0_ov || ordy0;
      e_rdy = acc ? (4'b0001 << sel0) : 4'b0000;
      chk("rnd_rdy0", rdy0, e_rdy);
      if (acc && iv0[sel0]) begin
        m0_ov = 1; m0_od = id0[sel0*8 +: 8]; m0_ch = sel0;
      end else if (ordy0) m0_ov = 0;
      // round robin
      acc = !m1_ov || ordy1;
      g = -1;
      for (int i = 1; i <= 4; i++)
        if (g < 0 && iv1[(ptr + i) % 4]) g = (ptr + i) % 4;
      e_rdy = (acc && g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rnd_rdy1", rdy1, e_rdy);
      if (acc && g >= 0) begin
        m1_ov = 1; m1_od = id1[g*8 +: 8]; m1_ch = 2'(g); ptr = g;
      end else if (ordy1) m1_ov = 0;
      // fixed select, 3 channels (sel 3 illegal)
      acc = !m3_ov || ordy3;
      legal = (sel3 < 3);
      e_rdy3 = (acc && legal) ? (3'b001 << sel3) : 3'b000;
      chk("rnd_rdy3", rdy3, e_rdy3);
      m3_err = acc && !legal;
      if (m3_err && m3_cnt != 16'hFFFF) m3_cnt = m3_cnt + 16'd1;
      if (acc && legal && iv3[sel3]) begin
        m3_ov = 1; m3_od = id3[sel3*8 +: 8]; m3_ch = sel3;
      end else if (ordy3) m3_ov = 0;
      cycle();
      chk("rnd_ov0", ov0, m0_ov);
      if (m0_ov) begin chk("rnd_od0", od0, m0_od); chk("rnd_och0", och0, m0_ch); end
      chk("rnd_ov1", ov1, m1_ov);
      if (m1_ov) begin chk("rnd_od1", od1, m1_od); chk("rnd_och1", och1, m1_ch); end
      chk("rnd_ov3", ov3, m3_ov);
      if (m3_ov) begin chk("rnd_od3", od3, m3_od); chk("rnd_och3", och3, m3_ch); end
`ifdef SCALE_MUX_SELCHK_EN
      chk("rnd_se3", se3, m3_err);
      chk("rnd_ec3", ec3, m3_cnt);
      chk("rnd_se1", se1, 0);
      chk("rnd_ec1", ec1, 0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
